// File: rtl/rx_regfile_if.sv
// UART receive line plus the register-file image and status it produces.
// master drives rx (the line side), slave is the receiver.
interface rx_regfile_if;
  logic          rx;
  logic [1023:0] reg_file;
  logic          regfile_rcv;
  logic          frame_err;
  logic          busy;

  modport master (
    output rx,
    input  reg_file, regfile_rcv, frame_err, busy
  );

  modport slave (
    input  rx,
    output reg_file, regfile_rcv, frame_err, busy
  );
endinterface

// File: rtl/rx_regfile.sv
// 8N1 UART receiver assembling 128 bytes into a 1024-bit register-file image.
// Optional idle-gap frame abort when RX_REGFILE_TIMEOUT_EN is defined.
module rx_regfile #(
  parameter int CLKS_PER_BIT = 104,
  parameter int TIMEOUT_CLKS = 20800
) (
  input logic         clk12,
  input logic         rstn,
  rx_regfile_if.slave bus
);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] clk_cnt, clk_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shreg, sh_n;
  logic [6:0]    byte_count;
  logic [1023:0] regs;
  logic          rcv, ferr;
  logic          meta, rxs;
  logic          wr, bad, tmo;

  always_ff @(posedge clk12 or negedge rstn) begin
    if (!rstn) begin
      meta <= 1'b1;
      rxs  <= 1'b1;
    end else begin
      meta <= bus.rx;
      rxs  <= meta;
    end
  end

  always_comb begin
    state_n = state;
    clk_n   = clk_cnt;
    bit_n   = bit_cnt;
    sh_n    = shreg;
    wr      = 1'b0;
    bad     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxs) begin
          state_n = START;
          clk_n   = '0;
        end
      end
      START: begin
        if (clk_cnt == CW'(HALF - 1)) begin
          clk_n   = '0;
          bit_n   = '0;
          state_n = rxs ? IDLE : DATA;
        end else begin
          clk_n = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
          clk_n = '0;
          sh_n  = {rxs, shreg[7:1]};
          bit_n = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_n = STOP;
        end else begin
          clk_n = clk_cnt + 1'b1;
        end
      end
      STOP: begin
        if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
          clk_n   = '0;
          state_n = IDLE;
          wr      = rxs;
          bad     = !rxs;
        end else begin
          clk_n = clk_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef RX_REGFILE_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT_CLKS + 1);
  logic [GW-1:0] gap;
  logic          gap_run;

  // Counts only while waiting between bytes of a partial frame.
  assign gap_run = (state == IDLE) && (byte_count != 7'd0) && rxs;
  assign tmo     = gap_run && (gap == GW'(TIMEOUT_CLKS - 1));

  always_ff @(posedge clk12 or negedge rstn) begin
    if (!rstn)        gap <= '0;
    else if (tmo)     gap <= '0;
    else if (gap_run) gap <= gap + 1'b1;
    else              gap <= '0;
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk12 or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      byte_count <= '0;
      regs       <= '0;
      rcv        <= 1'b0;
      ferr       <= 1'b0;
    end else begin
      state   <= state_n;
      clk_cnt <= clk_n;
      bit_cnt <= bit_n;
      shreg   <= sh_n;
      rcv     <= 1'b0;
      ferr    <= 1'b0;
      if (wr) begin
        regs[8*byte_count +: 8] <= shreg;
        byte_count              <= byte_count + 1'b1;
        rcv                     <= (byte_count == 7'd127);
      end else if (bad || tmo) begin
        byte_count <= '0;
        ferr       <= 1'b1;
      end
    end
  end

  assign bus.reg_file    = regs;
  assign bus.regfile_rcv = rcv;
  assign bus.frame_err   = ferr;
  assign bus.busy        = (state != IDLE) || (byte_count != 7'd0);
endmodule

// File: tb/tb_rx_regfile.sv
// Directed bench for rx_regfile: full frames, glitch, framing error,
// mid-frame reset, optional idle timeout, back-to-back frames.
module tb_rx_regfile;
  localparam int CPB = 8;
  localparam int TO  = 2000;
  localparam int FRAME_CYC = 128 * 10 * CPB;

  logic clk12 = 1'b0;
  logic rstn  = 1'b0;
  rx_regfile_if bus ();

  rx_regfile #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
    .clk12 (clk12),
    .rstn  (rstn),
    .bus   (bus.slave)
  );

  always #5 clk12 = ~clk12;

  int total = 0;
  int bad   = 0;
  int rcv_cnt  = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  int cyc = 0;
  int rcv_t = 0;
  int rcv_t_prev = 0;
  logic [1023:0] snap = '0;
  logic [1023:0] snap_prev = '0;
  logic [1023:0] expv;
  logic [7:0] fb [128];

  always @(negedge clk12) begin
    cyc++;
    if (bus.regfile_rcv) begin
      rcv_cnt++;
      snap_prev  = snap;
      snap       = bus.reg_file;
      rcv_t_prev = rcv_t;
      rcv_t      = cyc;
    end
    if (bus.frame_err) ferr_cnt++;
    if (bus.regfile_rcv && bus.frame_err) both_cnt++;
  end

  task automatic chk(input string tag, input logic [1023:0] obs,
                     input logic [1023:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk12);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk12);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      repeat (CPB) @(negedge clk12);
    end
    bus.rx = stop;
    repeat (CPB) @(negedge clk12);
    bus.rx = 1'b1;
  endtask

  task automatic send_frame();
    for (int k = 0; k < 128; k++) send_byte(fb[k], 1'b1);
  endtask

  task automatic fill(input logic [7:0] v);
    for (int k = 0; k < 128; k++) fb[k] = v;
  endtask

  task automatic build_exp();
    for (int k = 0; k < 128; k++) expv[8*k +: 8] = fb[k];
  endtask

  initial begin
    int r0, f0;
    bus.rx = 1'b1;
    repeat (3) @(negedge clk12);
    chk("rst_reg_file", bus.reg_file, '0);
    chk("rst_rcv", bus.regfile_rcv, 0);
    chk("rst_ferr", bus.frame_err, 0);
    chk("rst_busy", bus.busy, 0);
    rstn = 1'b1;
    idle(2 * CPB);

    // ascending bytes 0..127
    for (int k = 0; k < 128; k++) fb[k] = 8'(k);
    build_exp();
    r0 = rcv_cnt; f0 = ferr_cnt;
    send_frame();
    idle(4);
    chk("asc_rcv_pulses", rcv_cnt - r0, 1);
    chk("asc_ferr", ferr_cnt - f0, 0);
    chk("asc_snap", snap, expv);
    chk("asc_reg1", snap[63:32], 32'h07060504);
    chk("asc_reg31", bus.reg_file[1023:992], 32'h7f7e7d7c);
    chk("asc_busy", bus.busy, 0);

    // short glitch then one byte
    bus.rx = 1'b0;
    repeat (3) @(negedge clk12);
    idle(3 * CPB);
    chk("glitch_busy", bus.busy, 0);
    send_byte(8'hA5, 1'b1);
    idle(4);
    chk("glitch_byte0", bus.reg_file[7:0], 8'hA5);
    chk("glitch_byte1_kept", bus.reg_file[15:8], 8'h01);
    chk("glitch_busy_cnt1", bus.busy, 1);

    // bytes 1..9 good, byte 10 bad stop, then a full 3C frame
    f0 = ferr_cnt; r0 = rcv_cnt;
    for (int k = 1; k < 10; k++) send_byte(8'h55, 1'b1);
    send_byte(8'h99, 1'b0);
    idle(2 * CPB);
    chk("ferr_pulse", ferr_cnt - f0, 1);
    chk("ferr_busy_clear", bus.busy, 0);
    chk("ferr_byte10_dropped", bus.reg_file[87:80], 8'h0a);
    fill(8'h3C);
    build_exp();
    send_frame();
    idle(4);
    chk("ferr_rcv_pulses", rcv_cnt - r0, 1);
    chk("ferr_only_one", ferr_cnt - f0, 1);
    chk("ferr_frame", snap, expv);

    // reset during byte 50
    fill(8'h77);
    for (int k = 0; k < 50; k++) send_byte(fb[k], 1'b1);
    bus.rx = 1'b0;
    repeat (3 * CPB) @(negedge clk12);
    rstn = 1'b0;
    repeat (3) @(negedge clk12);
    chk("mid_rst_reg_file", bus.reg_file, '0);
    chk("mid_rst_rcv", bus.regfile_rcv, 0);
    chk("mid_rst_ferr", bus.frame_err, 0);
    chk("mid_rst_busy", bus.busy, 0);
    rstn = 1'b1;
    idle(3 * CPB);
    for (int k = 0; k < 128; k++) fb[k] = 8'(3 * k + 1);
    build_exp();
    r0 = rcv_cnt; f0 = ferr_cnt;
    send_frame();
    idle(4);
    chk("post_rst_rcv", rcv_cnt - r0, 1);
    chk("post_rst_ferr", ferr_cnt - f0, 0);
    chk("post_rst_frame", snap, expv);

`ifdef RX_REGFILE_TIMEOUT_EN
    f0 = ferr_cnt; r0 = rcv_cnt;
    for (int k = 0; k < 20; k++) send_byte(8'h5A, 1'b1);
    idle(TO + 500);
    chk("tmo_ferr", ferr_cnt - f0, 1);
    chk("tmo_busy", bus.busy, 0);
    chk("tmo_no_rcv", rcv_cnt - r0, 0);
    fill(8'hFF);
    send_frame();
    idle(4);
    chk("tmo_rcv", rcv_cnt - r0, 1);
    chk("tmo_frame", bus.reg_file, {1024{1'b1}});
    chk("tmo_ferr_once", ferr_cnt - f0, 1);
`endif

    // two frames with no gap
    r0 = rcv_cnt;
    fill(8'h11);
    send_frame();
    fill(8'h22);
    send_frame();
    idle(4);
    chk("b2b_rcv", rcv_cnt - r0, 2);
    chk("b2b_interval", rcv_t - rcv_t_prev, FRAME_CYC);
    chk("b2b_first", snap_prev, {128{8'h11}});
    chk("b2b_second", bus.reg_file, {128{8'h22}});
    chk("never_both", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
